reaction_timer: RTL

//  Core measurement FSM of the reaction meter. Consumes the 1 ms tick pulse from the

---
 rtl/reaction_timer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
// Reaction meter core: random pre-stimulus wait, stimulus LED, BCD millisecond
// count until the button press, with false-start and timeout flagging.
//
// Handshake note: this block has no valid/ready channels. start is a level
// whose rising edge requests a run; tick_ms is a single-cycle strobe; the
// result is valid (and held) whenever done is high.
module reaction_timer #(
   parameter int MIN_WAIT_MS = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_ms,
   input  logic        start,
   input  logic        button,
   input  logic [9:0]  rand_ms,
   output logic        led,
   output logic        busy,
   output logic        done,
   output logic        foul,
   output logic        timeout,
   output logic [15:0] result
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FOUL  = 3'd4;

   localparam logic [13:0] MIN_W = 14'(MIN_WAIT_MS);

   logic [2:0]  state;
   logic        start_q;
   logic        start_edge;
   logic [13:0] wait_cnt;
   logic [15:0] result_q;
   logic        timeout_q;

   // Saturating-free BCD increment; the caller handles the 9999 ceiling.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign start_edge = start & ~start_q;

   // Previous start level for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_q <= 1'b0;
      else        start_q <= start;
   end

   // Measurement FSM with wait counter, BCD result and timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wait_cnt  <= 14'd0;
         result_q  <= 16'h0000;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_FOUL: begin
               // A press held at the start edge would be an instant foul, so
               // such a start is simply not accepted.
               if (start_edge && !button) begin
                  state     <= S_WAIT;
                  result_q  <= 16'h0000;
                  timeout_q <= 1'b0;
                  wait_cnt  <= MIN_W + {4'b0000, rand_ms};
               end
            end
            S_WAIT: begin
               if (button) begin
                  state <= S_FOUL;
               end else if (tick_ms) begin
                  if (wait_cnt == 14'd1) state <= S_ARMED;
                  else                   wait_cnt <= wait_cnt - 14'd1;
               end
            end
            S_ARMED: begin
               // The press wins over a coincident tick: time truncates.
               if (button) begin
                  state <= S_DONE;
               end else if (tick_ms) begin
                  if (result_q == 16'h9999) begin
                     state     <= S_DONE;
                     timeout_q <= 1'b1;
                  end else begin
                     result_q <= bcd_inc(result_q);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decoded straight from the registered state.
   always_comb begin
      led     = (state == S_ARMED);
      busy    = (state == S_WAIT) || (state == S_ARMED);
      done    = (state == S_DONE);
      foul    = (state == S_FOUL);
      timeout = timeout_q && (state == S_DONE);
      result  = result_q;
   end

endmodule
